ahb_arbiter_param: RTL and testbench
====================================

Name: ahb_arbiter_param

Overview:
Parametrised AHB bus arbiter for the multi-master interconnect. It replaces the fixed 16-master arbiter and supports a configurable master count, fixed-priority or round-robin selection, and default-master parking. It holds ownership through locked sequences and fixed-length bursts. It drives the one-hot grant vector plus hmaster/hmastlock, which feed the master-side address/write-data muxes and the slaves.

Parameters:
NUM_MASTERS, 16, number of requesting masters (2..16)
MASTER_W, 4, width of hmaster; must satisfy 2**MASTER_W >= NUM_MASTERS
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
DEFAULT_MASTER, 0, index granted when nobody requests (bus parking)

Ports:
hclk  in  1  bus clock; all state updates on rising edge
hresetn  in  1  synchronous active-low reset, sampled on the rising edge of hclk
hbusreq  in  NUM_MASTERS  bus request, one bit per master
hlock  in  NUM_MASTERS  locked-access request, one bit per master
htrans  in  2  transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
hburst  in  3  burst type of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
hready  in  1  transfer-complete from slave mux
hgrant  out  NUM_MASTERS  one-hot grant, registered
hmaster  out  MASTER_W  index of the address-phase owner, registered
hmastlock  out  1  current address phase is locked, registered

Behaviour:
- Reset (hresetn=0 at a clock edge): hgrant = one-hot DEFAULT_MASTER; hmaster = DEFAULT_MASTER; hmastlock = 0; last_grant = DEFAULT_MASTER; beat_cnt = 0; FSM = PARK. Reset applied mid-burst or mid-lock aborts the operation immediately. No state is retained.
- Internal g_idx = encoded index of hgrant.
- Update rule: all registers except the reset path change only on edges where hready=1. With hready=0, every output holds.
- Handover: hmaster <= g_idx and hmastlock <= hlock[g_idx] on each hready=1 edge. hmaster therefore trails hgrant by exactly one completed transfer, which is the AHB address-phase handover.
- Beat counter (beat_cnt, 5 bits), on hready=1 edges:
  - htrans=NONSEQ with a fixed-length hburst: load beats-1 (4→3, 8→7, 16→15).
  - htrans=SEQ with beat_cnt>0: decrement.
  - htrans=IDLE, or NONSEQ with SINGLE or INCR: clear to 0 (early burst termination).
  - BUSY: hold.
- Hold condition: hold = (beat_cnt > 1) | hlock[g_idx] | hmastlock. Arbitration happens on an hready=1 edge only when hold=0. This lets the grant move during the final beat of a fixed burst, so the new master's address phase follows the last beat with no gap.
- Selection, when arbitrating:
  - RR_MODE=1: first requesting master searching from last_grant+1 upward, wrapping modulo NUM_MASTERS. last_grant itself is considered last.
  - RR_MODE=0: lowest-index requester.
  - No requester: DEFAULT_MASTER.
  - last_grant updates only when a requesting master is granted, never on parking.
- A granted master that keeps hbusreq high with hold=0 is still re-arbitrated every transfer:
  - RR mode: it yields to any other requester.
  - Fixed mode: it keeps the bus unless a lower index requests.
- FSM, informational, derived from the above:
  - PARK: grant is default and there is no request.
  - OWNED: granted with hold=0.
  - BURST: beat_cnt > 1.
  - LOCKED: hlock or hmastlock is set.
  - Transitions follow the hold and selection rules. While in LOCKED or BURST, a request from another master has no effect.
- Simultaneous events:
  - Burst end coincides with hlock rising: lock wins and the grant holds.
  - hbusreq and hlock bits for non-granted masters are ignored until arbitration.
- Width rules: hmaster is zero-extended when NUM_MASTERS < 2**MASTER_W. Indices >= NUM_MASTERS are never produced.
- Invariant: hgrant is always exactly one-hot.

Test Plan:
- Reset/park: hresetn=0 for 2 cycles, then no requests with hready=1 → hgrant=16'h0001, hmaster=0, hmastlock=0, held indefinitely.
- Round-robin fairness: hbusreq=16'h0092 (masters 1, 4, 7) held, SINGLE transfers, hready=1 → grants cycle 1→4→7→1. hmaster follows each grant one cycle later.
- Fixed priority (RR_MODE=0): hbusreq=16'h0092 → master 1 keeps the grant; drop bit 1 → master 4 is granted on the next hready edge.
- INCR8 burst hold: master 2 granted, NONSEQ/INCR8 then 7 SEQ, master 5 requesting throughout → hgrant moves to master 5 on the edge completing beat 7, not earlier. Insert hready=0 on beat 3 → all outputs freeze for that cycle.
- Locked sequence: master 3 with hlock=1 for 3 transfers while master 0 requests → grant stays 3. hmastlock=1 during those address phases. Grant moves to 0 one transfer after hlock drops (hmastlock clears first).
- Early termination and reset mid-burst: INCR16 interrupted by IDLE after 5 beats → re-arbitration on the next hready edge. Separately, hresetn=0 mid-INCR4 → outputs return to reset values at that edge.

Source files
------------

// File: rtl/ahb_arbiter_param_if.sv
// AHB arbitration signal bundle shared by the requesting masters and the arbiter.
// The master modport is the requester side; the slave modport is taken by the arbiter.
interface ahb_arbiter_param_if #(
    parameter int unsigned NUM_MASTERS = 16,
    parameter int unsigned MASTER_W    = 4
) ();

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic [2:0]             hburst;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MASTER_W-1:0]    hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );

endinterface

// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB arbiter: round-robin or fixed priority, default-master parking,
// ownership held through locked sequences and fixed-length bursts.
module ahb_arbiter_param #(
    parameter int unsigned NUM_MASTERS    = 16,
    parameter int unsigned MASTER_W       = 4,
    parameter int unsigned RR_MODE        = 1,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input logic             hclk,
    input logic             hresetn,
    ahb_arbiter_param_if.slave bus
);

    localparam logic [1:0] HtransIdle   = 2'd0;
    localparam logic [1:0] HtransBusy   = 2'd1;
    localparam logic [1:0] HtransNonseq = 2'd2;
    localparam logic [1:0] HtransSeq    = 2'd3;

    localparam logic [NUM_MASTERS-1:0] DefGrant = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MASTER_W-1:0]    DefIdx   = MASTER_W'(DEFAULT_MASTER);

    typedef enum logic [1:0] {StPark, StOwned, StBurst, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MASTER_W-1:0]    hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [MASTER_W-1:0]    last_q, last_d;
    logic [4:0]             beat_q, beat_d;

    logic [MASTER_W-1:0]    g_idx;
    logic                   lock_cur;
    logic                   hold;
    logic [MASTER_W-1:0]    sel_lo, sel_hi, sel;
    logic                   found_lo, found_hi;

    // Grant is one-hot, so OR-ing the indices of set bits yields the encoded owner.
    always_comb begin
        g_idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) g_idx |= MASTER_W'(i);
        end
    end

    assign lock_cur = |(bus.hlock & grant_q);

    // StLocked mirrors hmastlock, StBurst mirrors beat_cnt > 1.
    assign hold = lock_cur | (state_q == StBurst) | (state_q == StLocked);

    // Round-robin: first requester above last_grant, else wrap to the lowest requester.
    always_comb begin
        sel_lo   = '0;
        sel_hi   = '0;
        found_lo = 1'b0;
        found_hi = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (bus.hbusreq[i] && !found_lo) begin
                sel_lo   = MASTER_W'(i);
                found_lo = 1'b1;
            end
            if (bus.hbusreq[i] && !found_hi && (MASTER_W'(i) > last_q)) begin
                sel_hi   = MASTER_W'(i);
                found_hi = 1'b1;
            end
        end
        sel = ((RR_MODE != 0) && found_hi) ? sel_hi : sel_lo;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        last_d      = last_q;
        beat_d      = beat_q;

        if (bus.hready) begin
            hmaster_d   = g_idx;
            hmastlock_d = lock_cur;

            unique case (bus.htrans)
                HtransIdle: beat_d = 5'd0;
                HtransBusy: beat_d = beat_q;
                HtransNonseq: begin
                    unique case (bus.hburst)
                        3'd2, 3'd3: beat_d = 5'd3;
                        3'd4, 3'd5: beat_d = 5'd7;
                        3'd6, 3'd7: beat_d = 5'd15;
                        default:    beat_d = 5'd0;
                    endcase
                end
                HtransSeq: begin
                    if (beat_q != 5'd0) beat_d = beat_q - 5'd1;
                end
                default: beat_d = beat_q;
            endcase

            if (!hold) begin
                if (found_lo) begin
                    grant_d = NUM_MASTERS'(1) << sel;
                    last_d  = sel;
                end else begin
                    grant_d = DefGrant;
                end
            end

            if (hmastlock_d) begin
                state_d = StLocked;
            end else if (beat_d > 5'd1) begin
                state_d = StBurst;
            end else if ((grant_d == DefGrant) && !found_lo) begin
                state_d = StPark;
            end else begin
                state_d = StOwned;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q     <= StPark;
            grant_q     <= DefGrant;
            hmaster_q   <= DefIdx;
            hmastlock_q <= 1'b0;
            last_q      <= DefIdx;
            beat_q      <= 5'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
        end
    end

    assign bus.hgrant    = grant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Bench for ahb_arbiter_param: a 16-master round-robin instance and a 6-master fixed-priority
// instance driven in lockstep and compared each cycle against a behavioural model.
module tb_ahb_arbiter_param;

    logic hclk = 1'b0;
    logic hresetn;
    always #5 hclk = ~hclk;

    ahb_arbiter_param_if #(.NUM_MASTERS(16), .MASTER_W(4)) bus0 ();
    ahb_arbiter_param_if #(.NUM_MASTERS(6),  .MASTER_W(4)) bus1 ();

    ahb_arbiter_param #(
        .NUM_MASTERS(16), .MASTER_W(4), .RR_MODE(1), .DEFAULT_MASTER(0)
    ) u_rr (
        .hclk(hclk), .hresetn(hresetn), .bus(bus0)
    );

    ahb_arbiter_param #(
        .NUM_MASTERS(6), .MASTER_W(4), .RR_MODE(0), .DEFAULT_MASTER(2)
    ) u_fix (
        .hclk(hclk), .hresetn(hresetn), .bus(bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    int nm[2]  = '{16, 6};
    int rrm[2] = '{1, 0};
    int dm[2]  = '{0, 2};

    // Model state: owner index, address-phase owner, lock flag, last requester granted, beats left.
    int m_g[2], m_hm[2], m_hml[2], m_last[2], m_beats[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic [15:0] rq, input logic [15:0] lk,
                              input logic [1:0] tr, input logic [2:0] bu,
                              input logic rd, input logic rs);
        int n;
        bit hold;
        bit found;
        int sel;
        int idx;
        n = nm[k];
        if (!rs) begin
            m_g[k] = dm[k]; m_hm[k] = dm[k]; m_hml[k] = 0; m_last[k] = dm[k]; m_beats[k] = 0;
            return;
        end
        if (!rd) return;
        hold = (m_beats[k] > 1) || (lk[m_g[k]] == 1'b1) || (m_hml[k] != 0);
        m_hm[k]  = m_g[k];
        m_hml[k] = int'(lk[m_g[k]]);
        case (tr)
            2'd0: m_beats[k] = 0;
            2'd1: ;
            2'd2: m_beats[k] = (bu == 3'd2 || bu == 3'd3) ? 3 :
                               (bu == 3'd4 || bu == 3'd5) ? 7 :
                               (bu >= 3'd6) ? 15 : 0;
            default: if (m_beats[k] > 0) m_beats[k] = m_beats[k] - 1;
        endcase
        if (!hold) begin
            found = 0;
            sel = 0;
            if (rrm[k] != 0) begin
                for (int j = 1; j <= n; j++) begin
                    idx = (m_last[k] + j) % n;
                    if (!found && rq[idx]) begin sel = idx; found = 1; end
                end
            end else begin
                for (int j = 0; j < n; j++) begin
                    if (!found && rq[j]) begin sel = j; found = 1; end
                end
            end
            if (found) begin
                m_g[k] = sel;
                m_last[k] = sel;
            end else begin
                m_g[k] = dm[k];
            end
        end
    endtask

    task automatic step(input logic [15:0] rq, input logic [15:0] lk, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rd, input logic rs);
        hresetn = rs;
        bus0.hbusreq = rq;      bus0.hlock = lk;
        bus0.htrans  = tr;      bus0.hburst = bu;  bus0.hready = rd;
        bus1.hbusreq = rq[5:0]; bus1.hlock = lk[5:0];
        bus1.htrans  = tr;      bus1.hburst = bu;  bus1.hready = rd;
        @(posedge hclk);
        model_step(0, rq, lk, tr, bu, rd, rs);
        model_step(1, rq, lk, tr, bu, rd, rs);
        #1;
        check_eq("rr_grant",    32'(bus0.hgrant),    32'd1 << m_g[0]);
        check_eq("rr_hmaster",  32'(bus0.hmaster),   32'(m_hm[0]));
        check_eq("rr_mastlock", 32'(bus0.hmastlock), 32'(m_hml[0]));
        check_eq("fx_grant",    32'(bus1.hgrant),    32'd1 << m_g[1]);
        check_eq("fx_hmaster",  32'(bus1.hmaster),   32'(m_hm[1]));
        check_eq("fx_mastlock", 32'(bus1.hmastlock), 32'(m_hml[1]));
    endtask

    initial begin
        logic [15:0] rq, lk;

        // Reset then parking on the default master.
        repeat (2) step(16'h0, 16'h0, 2'd0, 3'd0, 1'b1, 1'b0);
        check_eq("rst_grant",   32'(bus0.hgrant),  32'h1);
        check_eq("rst_fx_grant", 32'(bus1.hgrant), 32'h4);
        check_eq("rst_fx_hmaster", 32'(bus1.hmaster), 32'h2);
        repeat (6) step(16'h0, 16'h0, 2'd0, 3'd0, 1'b1, 1'b1);
        check_eq("park_grant",    32'(bus0.hgrant),    32'h1);
        check_eq("park_hmaster",  32'(bus0.hmaster),   32'h0);
        check_eq("park_mastlock", 32'(bus0.hmastlock), 32'h0);

        // Masters 1, 4, 7 with single transfers: RR cycles, fixed keeps master 1.
        repeat (12) step(16'h0092, 16'h0, 2'd2, 3'd0, 1'b1, 1'b1);
        check_eq("fx_keeps_1", 32'(bus1.hgrant), 32'h02);
        step(16'h0090, 16'h0, 2'd2, 3'd0, 1'b1, 1'b1);
        check_eq("fx_moves_4", 32'(bus1.hgrant), 32'h10);

        // INCR8 by master 2; master 5 joins after the NONSEQ, one wait state on beat 3.
        repeat (3) step(16'h0004, 16'h0, 2'd0, 3'd0, 1'b1, 1'b1);
        step(16'h0004, 16'h0, 2'd2, 3'd5, 1'b1, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            if (j == 3) step(16'h0024, 16'h0, 2'd3, 3'd5, 1'b0, 1'b1);
            step(16'h0024, 16'h0, 2'd3, 3'd5, 1'b1, 1'b1);
            if (j == 6) check_eq("incr8_held", 32'(bus0.hgrant), 32'h04);
        end
        check_eq("incr8_handover", 32'(bus0.hgrant), 32'h20);

        // Locked sequence by master 3 while master 0 requests.
        repeat (2) step(16'h0008, 16'h0008, 2'd2, 3'd0, 1'b1, 1'b1);
        repeat (3) step(16'h0009, 16'h0008, 2'd2, 3'd0, 1'b1, 1'b1);
        check_eq("lock_held",     32'(bus0.hgrant),    32'h08);
        check_eq("lock_mastlock", 32'(bus0.hmastlock), 32'h1);
        step(16'h0009, 16'h0, 2'd2, 3'd0, 1'b1, 1'b1);
        check_eq("unlock_grant", 32'(bus0.hgrant), 32'h08);
        step(16'h0009, 16'h0, 2'd2, 3'd0, 1'b1, 1'b1);
        check_eq("unlock_move", 32'(bus0.hgrant), 32'h01);

        // INCR16 by master 1 terminated by IDLE after 5 beats.
        repeat (2) step(16'h0002, 16'h0, 2'd0, 3'd0, 1'b1, 1'b1);
        step(16'h0002, 16'h0, 2'd2, 3'd7, 1'b1, 1'b1);
        repeat (4) step(16'h0006, 16'h0, 2'd3, 3'd7, 1'b1, 1'b1);
        step(16'h0006, 16'h0, 2'd0, 3'd7, 1'b1, 1'b1);
        check_eq("term_held", 32'(bus0.hgrant), 32'h02);
        step(16'h0006, 16'h0, 2'd0, 3'd0, 1'b1, 1'b1);
        check_eq("term_move", 32'(bus0.hgrant), 32'h04);

        // Reset in the middle of an INCR4.
        step(16'h0004, 16'h0, 2'd2, 3'd3, 1'b1, 1'b1);
        step(16'h0004, 16'h0, 2'd3, 3'd3, 1'b1, 1'b1);
        step(16'h0004, 16'h0004, 2'd3, 3'd3, 1'b1, 1'b0);
        check_eq("midrst_grant",    32'(bus0.hgrant),    32'h1);
        check_eq("midrst_hmaster",  32'(bus0.hmaster),   32'h0);
        check_eq("midrst_mastlock", 32'(bus0.hmastlock), 32'h0);

        // Randomised traffic.
        for (int c = 0; c < 2000; c++) begin
            rq = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) & 16'($urandom));
            lk = ($urandom_range(0, 7) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0;
            step(rq, lk, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 149) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
